// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: decodes load/store width, steers byte lanes,
// extends load data and runs a valid/ack data-memory handshake that tolerates
// wait states and aborts on timeout.
module mem_access_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [XLEN-1:0]   data_write,
    output logic              req_ready,
    output logic              stall_o,
    output logic              load_valid_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic              misalign_o,
    output logic              fault_o,
    output logic              data_ce_o,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [XLEN-1:0]   data_o,
    input  logic [XLEN-1:0]   data_i,
    input  logic              data_ack_i
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ce_q, ce_d;
    logic               fault_q, fault_d;
    logic               misalign_q, misalign_d;
    logic               load_valid_q, load_valid_d;
    logic               we_q;
    logic [NB-1:0]      be_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [2:0]         funct3_q;
    logic [OFF_W-1:0]   off_q;
    logic [XLEN-1:0]    load_data_q;

    logic               is_op;
    logic               legal;
    logic               aligned;
    logic [OFF_W-1:0]   off;
    logic [NB-1:0]      be_c;
    logic [XLEN-1:0]    wdata_c;
    logic [XLEN-1:0]    lane;
    logic [XLEN-1:0]    load_fmt;
    logic               timeout_hit;
    logic               accept;
    logic               load_cap;

    assign is_op       = mem_read | mem_write;
    assign off         = address[OFF_W-1:0];
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Request decode: legality (store wins over load), alignment, lanes
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        be_c    = '0;
        wdata_c = '0;
        if (mem_write) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = (XLEN == 64);
                default:                legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (XLEN == 64);
                default:                                legal = 1'b0;
            endcase
        end
        case (funct3[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_c    = NB'(1) << off;
                wdata_c = {NB{data_write[7:0]}};
            end
            2'b01: begin
                aligned = ~address[0];
                be_c    = NB'(3) << off;
                wdata_c = {(NB/2){data_write[15:0]}};
            end
            2'b10: begin
                aligned = (address[1:0] == 2'b00);
                be_c    = NB'(4'hF) << off;
                wdata_c = {(NB/4){data_write[31:0]}};
            end
            default: begin
                aligned = (address[2:0] == 3'b000);
                be_c    = {NB{1'b1}};
                wdata_c = data_write;
            end
        endcase
    end

    // Load formatting: pick the lane at the captured offset, then extend
    always_comb begin
        lane     = data_i >> {off_q, 3'b000};
        load_fmt = lane;
        case (funct3_q[1:0])
            2'b00: begin
                if (funct3_q[2]) load_fmt = XLEN'(lane[7:0]);
                else             load_fmt = XLEN'($signed(lane[7:0]));
            end
            2'b01: begin
                if (funct3_q[2]) load_fmt = XLEN'(lane[15:0]);
                else             load_fmt = XLEN'($signed(lane[15:0]));
            end
            2'b10: begin
                if (funct3_q[2]) load_fmt = XLEN'(lane[31:0]);
                else             load_fmt = XLEN'($signed(lane[31:0]));
            end
            default: load_fmt = lane;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid && is_op && legal && aligned) state_d = S_ACCESS;
            S_ACCESS: if (data_ack_i || timeout_hit)              state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered strobes and counter
    always_comb begin
        accept       = 1'b0;
        load_cap     = 1'b0;
        ce_d         = 1'b0;
        fault_d      = 1'b0;
        misalign_d   = 1'b0;
        load_valid_d = 1'b0;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && is_op) begin
                    if (!legal) begin
                        fault_d = 1'b1;
                    end else if (!aligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        accept = 1'b1;
                        ce_d   = 1'b1;
                        cnt_d  = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (data_ack_i) begin
                    load_valid_d = ~we_q;
                    load_cap     = ~we_q;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                end else begin
                    ce_d  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered bus outputs, strobes, captured request and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            ce_q         <= 1'b0;
            fault_q      <= 1'b0;
            misalign_q   <= 1'b0;
            load_valid_q <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            load_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            ce_q         <= ce_d;
            fault_q      <= fault_d;
            misalign_q   <= misalign_d;
            load_valid_q <= load_valid_d;
            if (accept) begin
                we_q     <= mem_write;
                be_q     <= be_c;
                addr_q   <= {address[ADDR_W-1:OFF_W], OFF_W'(0)};
                wdata_q  <= wdata_c;
                funct3_q <= funct3;
                off_q    <= off;
            end
            if (load_cap) load_data_q <= load_fmt;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign stall_o      = ((state_q == S_IDLE) && req_valid && is_op && legal && aligned) ||
                          ((state_q == S_ACCESS) && !data_ack_i);
    assign data_ce_o    = ce_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_o       = wdata_q;
    assign load_valid_o = load_valid_q;
    assign load_data_o  = load_data_q;
    assign misalign_o   = misalign_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: XLEN=32 (TIMEOUT=4) instance driven from a
// vector table with a bus/load scoreboard, plus an XLEN=64 instance.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // XLEN=32 instance signals
    logic        a_rst_n, a_valid, a_rd, a_wr, a_ack;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata, a_din;
    logic        a_ready, a_stall, a_lv, a_mis, a_fault, a_ce, a_we;
    logic [31:0] a_ld, a_baddr, a_dout;
    logic [3:0]  a_be;

    // XLEN=64 instance signals
    logic        b_rst_n, b_valid, b_rd, b_wr, b_ack;
    logic [2:0]  b_f3;
    logic [31:0] b_addr, b_baddr;
    logic [63:0] b_wdata, b_din, b_ld, b_dout;
    logic        b_ready, b_stall, b_lv, b_mis, b_fault, b_ce, b_we;
    logic [7:0]  b_be;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .mem_read(a_rd),
        .mem_write(a_wr), .funct3(a_f3), .address(a_addr), .data_write(a_wdata),
        .req_ready(a_ready), .stall_o(a_stall), .load_valid_o(a_lv),
        .load_data_o(a_ld), .misalign_o(a_mis), .fault_o(a_fault),
        .data_ce_o(a_ce), .data_we_o(a_we), .data_be_o(a_be),
        .data_addr_o(a_baddr), .data_o(a_dout), .data_i(a_din), .data_ack_i(a_ack)
    );

    mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(8)) u64 (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .mem_read(b_rd),
        .mem_write(b_wr), .funct3(b_f3), .address(b_addr), .data_write(b_wdata),
        .req_ready(b_ready), .stall_o(b_stall), .load_valid_o(b_lv),
        .load_data_o(b_ld), .misalign_o(b_mis), .fault_o(b_fault),
        .data_ce_o(b_ce), .data_we_o(b_we), .data_be_o(b_be),
        .data_addr_o(b_baddr), .data_o(b_dout), .data_i(b_din), .data_ack_i(b_ack)
    );

    typedef struct {
        logic        we;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          waits;
        int          kind;   // 0 accepted, 1 misaligned, 2 illegal
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bdata;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic [31:0] ld;
        int          cyc;
    } ld_t;

    bus_t        bus_q[$];
    ld_t         ld_q[$];
    bus_t        bexp;
    ld_t         lexp;
    logic        ce_prev = 1'b0;
    logic [31:0] last_ld = '0;
    vec_t        vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the XLEN=32 instance
    always @(negedge clk) begin
        if (a_rst_n) begin
            if (a_ce && !ce_prev) begin
                chk("bus_expected", 64'(bus_q.size() != 0), 64'd1);
                if (bus_q.size() != 0) begin
                    bexp = bus_q.pop_front();
                    chk("bus_we", 64'(a_we), 64'(bexp.we));
                    chk("bus_be", 64'(a_be), 64'(bexp.be));
                    chk("bus_addr", 64'(a_baddr), 64'(bexp.addr));
                    if (bexp.we) chk("bus_data", 64'(a_dout), 64'(bexp.data));
                end
            end
            if (a_lv) begin
                chk("load_expected", 64'(ld_q.size() != 0), 64'd1);
                if (ld_q.size() != 0) begin
                    lexp = ld_q.pop_front();
                    chk("load_data", 64'(a_ld), 64'(lexp.ld));
                    chk("load_cycle", 64'(cyc), 64'(lexp.cyc));
                end
            end
        end
        ce_prev = a_ce;
    end

    task automatic run32(input vec_t v);
        a_valid = 1'b1; a_rd = v.rd; a_wr = v.we; a_f3 = v.f3;
        a_addr = v.addr; a_wdata = v.wd;
        @(negedge clk);
        chk("req_ready_idle", 64'(a_ready), 64'd1);
        chk("stall_request", 64'(a_stall), 64'(v.kind == 0));
        if (v.kind == 0) begin
            bus_q.push_back('{v.we, v.be, v.baddr, v.bdata});
            if (!v.we) begin
                ld_q.push_back('{v.ld, cyc + 2 + v.waits});
                last_ld = v.ld;
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
        if (v.kind == 0) begin
            for (int w = 0; w <= v.waits; w++) begin
                a_ack = (w == v.waits);
                a_din = v.rdata;
                @(negedge clk);
                chk("ce_access", 64'(a_ce), 64'd1);
                chk("stall_access", 64'(a_stall), 64'(w != v.waits));
                chk("req_ready_access", 64'(a_ready), 64'd0);
                @(posedge clk); #1;
            end
            a_ack = 1'b0;
            a_din = '0;
        end else begin
            @(negedge clk);
            chk("misalign_pulse", 64'(a_mis), 64'(v.kind == 1));
            chk("fault_pulse", 64'(a_fault), 64'(v.kind == 2));
            chk("ce_rejected", 64'(a_ce), 64'd0);
            chk("stall_rejected", 64'(a_stall), 64'd0);
            chk("load_hold", 64'(a_ld), 64'(last_ld));
            @(posedge clk); #1;
            @(negedge clk);
            chk("misalign_one_pulse", 64'(a_mis), 64'd0);
            chk("fault_one_pulse", 64'(a_fault), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run64(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rdat,
                         input logic [7:0] ebe, input logic [31:0] eaddr,
                         input logic [63:0] edata, input logic [63:0] eld);
        b_valid = 1'b1; b_wr = we; b_rd = ~we; b_f3 = f3; b_addr = addr; b_wdata = wd;
        @(posedge clk); #1;
        b_valid = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_ack = 1'b1; b_din = rdat;
        @(negedge clk);
        chk("x64_ce", 64'(b_ce), 64'd1);
        chk("x64_be", 64'(b_be), 64'(ebe));
        chk("x64_addr", 64'(b_baddr), 64'(eaddr));
        if (we) chk("x64_data", b_dout, edata);
        @(posedge clk); #1;
        b_ack = 1'b0; b_din = '0;
        @(negedge clk);
        chk("x64_load_valid", 64'(b_lv), 64'(!we));
        if (!we) chk("x64_load_data", b_ld, eld);
        chk("x64_ce_done", 64'(b_ce), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_zero32(input string tag);
        chk({tag, "_ce"}, 64'(a_ce), 64'd0);
        chk({tag, "_we"}, 64'(a_we), 64'd0);
        chk({tag, "_be"}, 64'(a_be), 64'd0);
        chk({tag, "_addr"}, 64'(a_baddr), 64'd0);
        chk({tag, "_data"}, 64'(a_dout), 64'd0);
        chk({tag, "_lv"}, 64'(a_lv), 64'd0);
        chk({tag, "_ld"}, 64'(a_ld), 64'd0);
        chk({tag, "_mis"}, 64'(a_mis), 64'd0);
        chk({tag, "_fault"}, 64'(a_fault), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we rd f3      addr    wd           rdata        w  k  be       baddr   bdata        ld
        vecs[0]  = '{1, 0, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 0, 4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0};
        vecs[1]  = '{0, 1, 3'b000, 32'h103, 32'h0,        32'hA5000000, 0, 0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFFA5};
        vecs[2]  = '{0, 1, 3'b100, 32'h103, 32'h0,        32'hA5000000, 1, 0, 4'b1000, 32'h100, 32'h0,        32'h000000A5};
        vecs[3]  = '{1, 0, 3'b001, 32'h202, 32'h00008001, 32'h0,        0, 0, 4'b1100, 32'h200, 32'h80018001, 32'h0};
        vecs[4]  = '{0, 1, 3'b001, 32'h202, 32'h0,        32'h80010000, 0, 0, 4'b1100, 32'h200, 32'h0,        32'hFFFF8001};
        vecs[5]  = '{0, 1, 3'b101, 32'h202, 32'h0,        32'h80010000, 3, 0, 4'b1100, 32'h200, 32'h0,        32'h00008001};
        vecs[6]  = '{1, 0, 3'b010, 32'h304, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'h304, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{0, 1, 3'b010, 32'h304, 32'h0,        32'h12345678, 2, 0, 4'b1111, 32'h304, 32'h0,        32'h12345678};
        vecs[8]  = '{0, 1, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 0, 4'b0010, 32'h100, 32'h0,        32'h0000007F};
        vecs[9]  = '{0, 1, 3'b010, 32'h301, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[10] = '{0, 1, 3'b001, 32'h203, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[11] = '{0, 1, 3'b011, 32'h300, 32'h0,        32'h0,        0, 2, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[12] = '{1, 0, 3'b100, 32'h300, 32'h0,        32'h0,        0, 2, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[13] = '{1, 1, 3'b101, 32'h200, 32'h0,        32'h0,        0, 2, 4'b0000, 32'h0,   32'h0,        32'h0};
        vecs[14] = '{1, 0, 3'b000, 32'h001, 32'h123456C3, 32'h0,        0, 0, 4'b0010, 32'h000, 32'hC3C3C3C3, 32'h0};
        vecs[15] = '{1, 1, 3'b001, 32'h006, 32'h0000BEEF, 32'h0,        0, 0, 4'b1100, 32'h004, 32'hBEEFBEEF, 32'h0};
        vecs[16] = '{0, 1, 3'b101, 32'h002, 32'h0,        32'h7FFF1234, 0, 0, 4'b1100, 32'h000, 32'h0,        32'h00007FFF};
        vecs[17] = '{1, 0, 3'b001, 32'h201, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,   32'h0,        32'h0};

        a_rst_n = 1'b0; a_valid = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_ack = 1'b0;
        a_f3 = '0; a_addr = '0; a_wdata = '0; a_din = '0;
        b_rst_n = 1'b0; b_valid = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_ack = 1'b0;
        b_f3 = '0; b_addr = '0; b_wdata = '0; b_din = '0;

        // Reset state
        #12;
        chk_zero32("reset");
        chk("reset_x64_ce", 64'(b_ce), 64'd0);
        chk("reset_x64_ld", b_ld, 64'd0);
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 64'(a_ready), 64'd1);
        chk("reset_stall", 64'(a_stall), 64'd0);
        @(posedge clk); #1;

        // Table-driven vectors, back-to-back
        for (int i = 0; i < 18; i++) run32(vecs[i]);

        // Timeout with TIMEOUT=4, then ack while idle is ignored
        a_valid = 1'b1; a_rd = 1'b1; a_wr = 1'b0; a_f3 = 3'b010; a_addr = 32'h400;
        bus_q.push_back('{1'b0, 4'hF, 32'h400, 32'h0});
        @(posedge clk); #1;
        a_valid = 1'b0; a_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("timeout_ce", 64'(a_ce), 64'd1);
            chk("timeout_no_fault_yet", 64'(a_fault), 64'd0);
            chk("timeout_stall", 64'(a_stall), 64'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("timeout_fault", 64'(a_fault), 64'd1);
        chk("timeout_ce_drop", 64'(a_ce), 64'd0);
        chk("timeout_idle", 64'(a_ready), 64'd1);
        chk("timeout_no_load", 64'(a_lv), 64'd0);
        @(posedge clk); #1;
        a_ack = 1'b1; a_din = 32'hFFFFFFFF;
        @(negedge clk);
        chk("timeout_fault_once", 64'(a_fault), 64'd0);
        chk("idle_ack_ce", 64'(a_ce), 64'd0);
        chk("idle_ack_stall", 64'(a_stall), 64'd0);
        @(posedge clk); #1;
        a_ack = 1'b0; a_din = '0;
        @(negedge clk);
        chk("idle_ack_no_load", 64'(a_lv), 64'd0);
        chk("idle_ack_load_hold", 64'(a_ld), 64'(last_ld));
        @(posedge clk); #1;

        // Reset in the middle of a store access
        a_valid = 1'b1; a_wr = 1'b1; a_f3 = 3'b010; a_addr = 32'h500; a_wdata = 32'hCAFEF00D;
        bus_q.push_back('{1'b1, 4'hF, 32'h500, 32'hCAFEF00D});
        @(posedge clk); #1;
        a_valid = 1'b0; a_wr = 1'b0;
        @(negedge clk);
        chk("midreset_ce_before", 64'(a_ce), 64'd1);
        @(posedge clk); #2;
        a_rst_n = 1'b0;
        #1;
        chk_zero32("midreset");
        chk("midreset_ready", 64'(a_ready), 64'd1);
        last_ld = '0;
        @(negedge clk);
        a_rst_n = 1'b1;
        @(negedge clk);
        chk("release_req_ready", 64'(a_ready), 64'd1);
        chk("release_ce", 64'(a_ce), 64'd0);
        @(posedge clk); #1;
        run32(vecs[1]);

        // XLEN=64 sequences
        run64(1'b1, 3'b011, 32'h8, 64'h1122334455667788, 64'h0,
              8'hFF, 32'h8, 64'h1122334455667788, 64'h0);
        run64(1'b0, 3'b110, 32'hC, 64'h0, 64'h80000000_12345678,
              8'hF0, 32'h8, 64'h0, 64'h00000000_80000000);
        run64(1'b0, 3'b010, 32'hC, 64'h0, 64'h80000000_12345678,
              8'hF0, 32'h8, 64'h0, 64'hFFFFFFFF_80000000);
        run64(1'b0, 3'b011, 32'h8, 64'h0, 64'h88776655_44332211,
              8'hFF, 32'h8, 64'h0, 64'h88776655_44332211);
        run64(1'b1, 3'b010, 32'h4, 64'hDEADBEEF, 64'h0,
              8'hF0, 32'h0, 64'hDEADBEEF_DEADBEEF, 64'h0);
        run64(1'b1, 3'b001, 32'hE, 64'hABCD, 64'h0,
              8'hC0, 32'h8, 64'hABCDABCD_ABCDABCD, 64'h0);
        run64(1'b0, 3'b000, 32'hD, 64'h0, 64'h00009100_00000000,
              8'h20, 32'h8, 64'h0, 64'hFFFFFFFF_FFFFFF91);

        // XLEN=64 misaligned doubleword
        b_valid = 1'b1; b_rd = 1'b1; b_f3 = 3'b011; b_addr = 32'h4;
        #1;
        chk("x64_misalign_no_stall", 64'(b_stall), 64'd0);
        @(posedge clk); #1;
        b_valid = 1'b0; b_rd = 1'b0;
        @(negedge clk);
        chk("x64_misalign", 64'(b_mis), 64'd1);
        chk("x64_misalign_ce", 64'(b_ce), 64'd0);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        chk("load_queue_drained", 64'(ld_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
